// File: rtl/riscv_mem_pkg.sv
// Shared data-side memory definitions: RV32I load/store size codes and the
// load/store sequencer state encoding, also used by the processor decoder.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'd0,
        LSU_READ  = 2'd1,
        LSU_WRITE = 2'd2,
        LSU_RESP  = 2'd3
    } lsu_state_t;

    // True when the size code is legal for the direction and the offset is aligned.
    function automatic logic access_ok(input logic is_store, input logic [2:0] f3,
                                       input logic [1:0] offset);
        logic legal;
        logic aligned;
        if (is_store) begin
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
        end
        case (f3[1:0])
            2'b01:   aligned = (offset[0] == 1'b0);
            2'b10:   aligned = (offset == 2'b00);
            default: aligned = 1'b1;
        endcase
        return legal && aligned;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: load extract/extend and sub-word store merge
// for a little-endian 32-bit word.
module lsu_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] word,
    input  logic [31:0] new_data,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed lane and extend it to a full load result.
    always_comb begin
        byte_sel = word[{offset, 3'b000} +: 8];
        if (offset[1]) begin
            half_sel = word[31:16];
        end else begin
            half_sel = word[15:0];
        end
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_data = {24'h000000, byte_sel};
            F3_HU:   load_data = {16'h0000, half_sel};
            default: load_data = word;
        endcase
    end

    // Replace only the addressed lane of the old word; full words pass straight through.
    always_comb begin
        store_word = word;
        case (funct3)
            F3_B: store_word[{offset, 3'b000} +: 8] = new_data[7:0];
            F3_H: begin
                if (offset[1]) begin
                    store_word[31:16] = new_data[15:0];
                end else begin
                    store_word[15:0] = new_data[15:0];
                end
            end
            default: store_word = new_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-side access sequencer: turns one load/store request into word-aligned
// memory cycles, with read-modify-write for byte and halfword stores.
module load_store_unit
    import riscv_mem_pkg::*;
#(
    parameter int MEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        fault,
    output logic        busy,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_we,
    input  logic [31:0] mem_RD
);

    lsu_state_t  state;
    logic [31:0] addr_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] wdata_q;
    logic [31:0] old_q;
    logic        fault_q;

    logic        bad_req;
    logic [31:0] lane_word;
    logic [31:0] load_data;
    logic [31:0] store_word;

    assign bad_req = !access_ok(we, funct3, addr[1:0]);

    // The merge works on the word saved during READ; loads extract straight from memory.
    assign lane_word = (state == LSU_WRITE) ? old_q : mem_RD;

    lsu_lane_align u_align (
        .offset     (addr_q[1:0]),
        .funct3     (funct3_q),
        .word       (lane_word),
        .new_data   (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    assign mem_A  = {addr_q[31:2], 2'b00};
    assign mem_WD = (state == LSU_WRITE) ? store_word : 32'h0000_0000;
    assign mem_we = (state == LSU_WRITE);
    assign busy   = (state != LSU_IDLE);
    assign done   = (state == LSU_RESP);
    assign fault  = (state == LSU_RESP) && fault_q;

    // Sequencer: capture, optional read, optional write, one response cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= LSU_IDLE;
            addr_q   <= 32'h0000_0000;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            wdata_q  <= 32'h0000_0000;
            old_q    <= 32'h0000_0000;
            fault_q  <= 1'b0;
            rdata    <= 32'h0000_0000;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (req) begin
                        addr_q   <= addr;
                        we_q     <= we;
                        funct3_q <= funct3;
                        wdata_q  <= wdata;
                        fault_q  <= bad_req;
                        if (bad_req) begin
                            state <= LSU_RESP;
                        end else if (we && (funct3 == F3_W)) begin
                            state <= LSU_WRITE;
                        end else begin
                            state <= LSU_READ;
                        end
                    end else begin
                        state <= LSU_IDLE;
                    end
                end
                LSU_READ: begin
                    if (we_q) begin
                        old_q <= mem_RD;
                        state <= LSU_WRITE;
                    end else begin
                        rdata <= load_data;
                        state <= LSU_RESP;
                    end
                end
                LSU_WRITE: state <= LSU_RESP;
                LSU_RESP:  state <= LSU_IDLE;
                default:   state <= LSU_IDLE;
            endcase
        end
    end

endmodule
